// File: rtl/lpixm_to_lpixs_bridge_v2_pkg.sv
// Shared widths, burst encodings and parcel-size helpers for the LPIXM->LPIXS bridge.
package lpixm_to_lpixs_bridge_v2_pkg;

  localparam int LPI_READY_NOW = 0;

  localparam int BW_LEN   = 8;
  localparam int BW_SIZE  = 3;
  localparam int BW_BURST = 2;

  typedef enum logic [BW_BURST-1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } lpi_burst_e;

  function automatic int bw_nz(input int w);
    return (w < 1) ? 1 : w;
  endfunction

  // {write, len, size, burst, byte_enable, wdata, addr}; burden is appended by the user
  function automatic int bw_lpixm_qparcel(input int ba, input int bd);
    return 1 + BW_LEN + BW_SIZE + BW_BURST + bd/8 + bd + ba;
  endfunction

  function automatic int bw_lpixm_yparcel(input int bd);
    return bd;
  endfunction

  function automatic int bw_lpixs_qparcel(input int ba, input int bd);
    return bw_lpixm_qparcel(ba, bd);
  endfunction

  function automatic int bw_lpixs_yparcel(input int bd);
    return bw_lpixm_yparcel(bd);
  endfunction

  // FIFO pointer index width; a depth-1 queue still gets one index bit
  function automatic int fifo_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lpixm_to_lpixs_bridge_v2_if.sv
// LPI request/response port bundle; the master modport drives requests, the slave modport answers.
interface lpixm_to_lpixs_bridge_v2_if #(
  parameter int BW_ADDR       = 32,
  parameter int BW_DATA       = 32,
  parameter int BW_LPI_BURDEN = 1
);
  localparam int BW_NZ = lpixm_to_lpixs_bridge_v2_pkg::bw_nz(BW_LPI_BURDEN);
  localparam int BW_Q  = lpixm_to_lpixs_bridge_v2_pkg::bw_lpixm_qparcel(BW_ADDR, BW_DATA) + BW_NZ;
  localparam int BW_Y  = lpixm_to_lpixs_bridge_v2_pkg::bw_lpixm_yparcel(BW_DATA) + BW_NZ;

  logic [1:0]      q_ready;
  logic            q_valid;
  logic            q_last;
  logic [BW_Q-1:0] q_parcel;
  logic [1:0]      y_ready;
  logic            y_valid;
  logic [BW_Y-1:0] y_parcel;

  modport master (input q_ready, output q_valid, q_last, q_parcel,
                  output y_ready, input y_valid, y_parcel);
  modport slave  (output q_ready, input q_valid, q_last, q_parcel,
                  input y_ready, output y_valid, y_parcel);
endinterface

// File: rtl/lpixm_bridge_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a synchronous flush.
module lpixm_bridge_fifo
  import lpixm_to_lpixs_bridge_v2_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [fifo_aw(DEPTH):0]  count
);
  localparam int AW = fifo_aw(DEPTH);

  logic [WIDTH-1:0] mem [1<<AW];
  logic [AW:0]      wp, rp;
  logic             do_push, do_pop;

  assign count   = wp - rp;
  assign empty   = (wp == rp);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      wp <= '0;
      rp <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lpixm_to_lpixs_bridge_v2.sv
// LPIXM->LPIXS bridge: burst framing, bounded outstanding transactions, burden restored on responses.
// Optional burst-legality checker enabled by defining LPIXM_BRIDGE_ERROR_CHECK_EN.
module lpixm_to_lpixs_bridge_v2
  import lpixm_to_lpixs_bridge_v2_pkg::*;
#(
  parameter int BW_ADDR         = 32,
  parameter int BW_DATA         = 32,
  parameter int BW_LPI_BURDEN   = 1,
  parameter int HEADER_DEPTH    = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic clk,
  input  logic rstnn,
  input  logic enable,
  input  logic clear,
  lpixm_to_lpixs_bridge_v2_if.slave  m_lpi,
  lpixm_to_lpixs_bridge_v2_if.master s_lpi,
  output logic error_detected
);
  localparam int BW_LPI_BURDEN_NZ = bw_nz(BW_LPI_BURDEN);
  localparam int BW_BE  = BW_DATA/8;
  localparam int BW_HDR = BW_LPI_BURDEN_NZ + 1 + BW_LEN + BW_SIZE + BW_BURST + BW_ADDR;
  localparam int BW_TRK = BW_LPI_BURDEN_NZ + 1 + BW_LEN;
  localparam int BW_Q   = bw_lpixs_qparcel(BW_ADDR, BW_DATA) + BW_LPI_BURDEN_NZ;
  localparam int BW_Y   = bw_lpixs_yparcel(BW_DATA) + BW_LPI_BURDEN_NZ;
  localparam int BW_OUT = $clog2(MAX_OUTSTANDING) + 1;

  logic [BW_LPI_BURDEN_NZ-1:0] m_burden, h_burden, t_burden;
  logic                        m_write, h_write, t_write;
  logic [BW_LEN-1:0]           m_len, h_len, t_len;
  logic [BW_SIZE-1:0]          m_size, h_size;
  logic [BW_BURST-1:0]         m_burst, h_burst;
  logic [BW_BE-1:0]            m_be;
  logic [BW_DATA-1:0]          m_wdata;
  logic [BW_ADDR-1:0]          m_addr, h_addr;

  logic [BW_HDR-1:0]                 hdr_head;
  logic [BW_TRK-1:0]                 trk_head;
  logic                              hdr_full, hdr_empty, trk_full, trk_empty;
  logic [fifo_aw(HEADER_DEPTH):0]    hdr_cnt;
  logic [fifo_aw(MAX_OUTSTANDING):0] trk_cnt;

  logic              sq_vld_r, sq_last_r;
  logic [BW_Q-1:0]   sq_parcel_r, beat_parcel;
  logic [BW_LEN-1:0] beat_rem, resp_cnt;
  logic [BW_OUT-1:0] outstanding;

  logic sq_valid, first_beat, beat_last, credit_ok, mq_ready_now, sy_ready_now;
  logic fire_m, fire_s, fire_y, hdr_pop, trk_pop, y_final;

  assign {m_burden, m_write, m_len, m_size, m_burst, m_be, m_wdata, m_addr} = m_lpi.q_parcel;
  assign {h_burden, h_write, h_len, h_size, h_burst, h_addr} = hdr_head;
  assign {t_burden, t_write, t_len} = trk_head;

  // Request side: one registered output stage fed by first or continuation beats
  assign first_beat = (beat_rem == '0);
  assign beat_last  = first_beat ? (~m_write | (m_len == '0)) : (beat_rem == BW_LEN'(1));
  assign beat_parcel = first_beat ? m_lpi.q_parcel
                                  : {h_burden, h_write, h_len, h_size, h_burst, m_be, m_wdata, h_addr};

  // Header-queue occupancy counts transactions not yet handed to the slave, so the sum never overruns the tracker
  assign credit_ok = ~first_beat |
                     (~hdr_full & ((int'(outstanding) + int'(hdr_cnt)) < MAX_OUTSTANDING));

  assign sq_valid     = sq_vld_r & enable;
  assign fire_s       = sq_valid & s_lpi.q_ready[LPI_READY_NOW];
  assign mq_ready_now = enable & ~clear & (~sq_valid | s_lpi.q_ready[LPI_READY_NOW]) & credit_ok;
  assign fire_m       = m_lpi.q_valid & mq_ready_now;
  assign hdr_pop      = fire_s & sq_last_r;

  assign m_lpi.q_ready  = {1'b0, mq_ready_now};
  assign s_lpi.q_valid  = sq_valid;
  assign s_lpi.q_last   = sq_last_r;
  assign s_lpi.q_parcel = sq_parcel_r;

  // Response side: tracker head supplies burden and the expected beat count
  assign sy_ready_now   = m_lpi.y_ready[LPI_READY_NOW] & ~trk_empty & enable;
  assign fire_y         = s_lpi.y_valid & sy_ready_now;
  assign y_final        = t_write | (resp_cnt == t_len);
  assign trk_pop        = fire_y & y_final;

  assign s_lpi.y_ready  = {1'b0, sy_ready_now};
  assign m_lpi.y_valid  = s_lpi.y_valid & ~trk_empty & enable;
  assign m_lpi.y_parcel = {t_burden, s_lpi.y_parcel[BW_DATA-1:0]};

  lpixm_bridge_fifo #(.WIDTH(BW_HDR), .DEPTH(HEADER_DEPTH)) u_hdr_q (
    .clk   (clk),
    .rstnn (rstnn),
    .clear (clear),
    .push  (fire_m & first_beat),
    .pop   (hdr_pop),
    .wdata ({m_burden, m_write, m_len, m_size, m_burst, m_addr}),
    .rdata (hdr_head),
    .full  (hdr_full),
    .empty (hdr_empty),
    .count (hdr_cnt)
  );

  lpixm_bridge_fifo #(.WIDTH(BW_TRK), .DEPTH(MAX_OUTSTANDING)) u_trk_q (
    .clk   (clk),
    .rstnn (rstnn),
    .clear (clear),
    .push  (hdr_pop),
    .pop   (trk_pop),
    .wdata ({h_burden, h_write, h_len}),
    .rdata (trk_head),
    .full  (trk_full),
    .empty (trk_empty),
    .count (trk_cnt)
  );

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      sq_vld_r    <= 1'b0;
      sq_last_r   <= 1'b0;
      sq_parcel_r <= '0;
      beat_rem    <= '0;
      outstanding <= '0;
      resp_cnt    <= '0;
    end else if (clear) begin
      sq_vld_r    <= 1'b0;
      sq_last_r   <= 1'b0;
      sq_parcel_r <= '0;
      beat_rem    <= '0;
      outstanding <= '0;
      resp_cnt    <= '0;
    end else begin
      if (fire_m) begin
        sq_vld_r    <= 1'b1;
        sq_last_r   <= beat_last;
        sq_parcel_r <= beat_parcel;
        beat_rem    <= first_beat ? (m_write ? m_len : '0) : beat_rem - BW_LEN'(1);
      end else if (fire_s) begin
        sq_vld_r <= 1'b0;
      end
      if (hdr_pop && !trk_pop)      outstanding <= outstanding + BW_OUT'(1);
      else if (trk_pop && !hdr_pop) outstanding <= outstanding - BW_OUT'(1);
      if (fire_y) resp_cnt <= y_final ? '0 : resp_cnt + BW_LEN'(1);
    end
  end

`ifdef LPIXM_BRIDGE_ERROR_CHECK_EN
  logic [17:0] span, end_addr;
  logic        err_hit;

  assign span     = (18'(m_len) + 18'd1) << m_size;
  assign end_addr = 18'(m_addr[11:0]) + span;
  assign err_hit  = fire_m & first_beat &
                    (((m_burst == BURST_INCR) & (end_addr > 18'd4096)) |
                     ((m_burst == BURST_WRAP) & !(m_len inside {8'd1, 8'd3, 8'd7, 8'd15})));

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)       error_detected <= 1'b0;
    else if (clear)   error_detected <= 1'b0;
    else if (err_hit) error_detected <= 1'b1;
  end
`else
  assign error_detected = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{m_lpi.q_last, m_lpi.y_ready[1], s_lpi.q_ready[1],
                       s_lpi.y_parcel[BW_Y-1:BW_DATA], hdr_empty, trk_full, trk_cnt};

endmodule
